// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA sync generator: pixel/line counters with clock-enable,
// programmable sync polarity, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  output logic [CW-1:0]      hpos,
  output logic [CW-1:0]      vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_MAX = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX = CW'(V_TOTAL - 1);

  // Window bounds are one bit wider so an end bound of exactly 2^CW still compares correctly.
  localparam logic [CW:0] H_VIS_X  = (CW+1)'(H_VISIBLE);
  localparam logic [CW:0] H_SS_X   = (CW+1)'(HS_START);
  localparam logic [CW:0] H_SE_X   = (CW+1)'(HS_END);
  localparam logic [CW:0] V_VIS_X  = (CW+1)'(V_VISIBLE);
  localparam logic [CW:0] V_SS_X   = (CW+1)'(VS_START);
  localparam logic [CW:0] V_SE_X   = (CW+1)'(VS_END);

  if (CW < 1 || CW > 30) begin : g_bad_cw
    $error("vga_timing_gen: CW must be in 1..30");
  end
  if (FRAME_W < 1) begin : g_bad_fw
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end
  if (H_VISIBLE < 1 || H_FRONT < 0 || H_SYNC < 0 || H_BACK < 0) begin : g_bad_hparm
    $error("vga_timing_gen: horizontal timing parameters out of range");
  end
  if (V_VISIBLE < 1 || V_FRONT < 0 || V_SYNC < 0 || V_BACK < 0) begin : g_bad_vparm
    $error("vga_timing_gen: vertical timing parameters out of range");
  end
  if (H_TOTAL > (1 << CW)) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
  end
  if (V_TOTAL > (1 << CW)) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
  end

  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] hpos_next;
  logic [CW-1:0] vpos_next;
  logic          hs_next;
  logic          vs_next;
  logic          de_next;

  // Decode from the next counter values so registered syncs line up with hpos/vpos.
  always_comb begin
    h_wrap    = (hpos == H_MAX);
    v_wrap    = (vpos == V_MAX);
    hpos_next = h_wrap ? '0 : hpos + CW'(1);
    vpos_next = vpos;
    if (h_wrap) begin
      vpos_next = v_wrap ? '0 : vpos + CW'(1);
    end
    hs_next = ({1'b0, hpos_next} >= H_SS_X) && ({1'b0, hpos_next} < H_SE_X);
    vs_next = ({1'b0, vpos_next} >= V_SS_X) && ({1'b0, vpos_next} < V_SE_X);
    de_next = ({1'b0, hpos_next} < H_VIS_X) && ({1'b0, vpos_next} < V_VIS_X);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= H_MAX;
      vpos        <= V_MAX;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '1;
    end else if (ce) begin
      hpos        <= hpos_next;
      vpos        <= vpos_next;
      hsync       <= hs_next ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_next ? VSYNC_POL : ~VSYNC_POL;
      display_on  <= de_next;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end else begin
      // Strobes last one clk even when ce stays low for several cycles.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
